// File: rtl/pbus_responder_if.sv
// Peripheral bus between the CPU memory stage and pbus_responder.
// The toggle in pbus_addr[31] starts a command; pbus_rdata[31] echoes it as ack.
interface pbus_responder_if;
   logic [31:0] pbus_addr;
   logic [31:0] pbus_wdata;
   logic [31:0] pbus_rdata;

   modport master (
      output pbus_addr,
      output pbus_wdata,
      input  pbus_rdata
   );

   modport slave (
      input  pbus_addr,
      input  pbus_wdata,
      output pbus_rdata
   );
endinterface

// File: rtl/pbus_responder.sv
// Toggle-handshake peripheral responder: ID, GPIO, timer, IRQ, scratch.
// Define PBUS_WDT_EN to add the watchdog at offset 0x20.
module pbus_responder #(
   parameter logic [23:0] ID_VALUE = 24'hB50001,
   parameter int          GPIO_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   pbus_responder_if.slave   bus,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq,
   output logic              wdt_rst
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nx;
   logic start, exec;

   logic        req_seen;
   logic        cap_we;
   logic [7:0]  cap_addr;
   logic [23:0] cap_wdata;
   logic        hold_err;
   logic [23:0] hold_data;

   logic [GPIO_W-1:0] sync1, sync2;
   logic [23:0] cnt, cmp, scratch;
   logic [7:0]  pre, prescale;
   logic        en, autoclr, irq_en, flag;

   logic        acc_err;
   logic [23:0] rd_val;
   logic        wr_gpio, wr_cmp, wr_ctrl, wr_stat, wr_scr;
   logic        tick, match, clr_wr;
`ifdef PBUS_WDT_EN
   logic        wr_wdt;
   logic [23:0] wdt_cnt;
   logic        wdt_arm;
`endif

   logic unused_bits;
   assign unused_bits = ^{bus.pbus_addr[29:8], bus.pbus_wdata[31:24]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      exec     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.pbus_addr[31] != req_seen) begin
               start    = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC: begin
            exec     = 1'b1;
            state_nx = RESP;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Register map decode for the captured command.
   always_comb begin
      acc_err = 1'b0;
      rd_val  = '0;
      wr_gpio = 1'b0;
      wr_cmp  = 1'b0;
      wr_ctrl = 1'b0;
      wr_stat = 1'b0;
      wr_scr  = 1'b0;
`ifdef PBUS_WDT_EN
      wr_wdt  = 1'b0;
`endif
      if (cap_addr[1:0] != 2'b00) begin
         acc_err = 1'b1;
      end else begin
         case (cap_addr[7:2])
            6'h00: begin
               rd_val  = ID_VALUE;
               acc_err = cap_we;
            end
            6'h01: begin
               rd_val  = 24'(gpio_out);
               wr_gpio = exec & cap_we;
            end
            6'h02: begin
               rd_val  = 24'(sync2);
               acc_err = cap_we;
            end
            6'h03: begin
               rd_val  = cnt;
               acc_err = cap_we;
            end
            6'h04: begin
               rd_val = cmp;
               wr_cmp = exec & cap_we;
            end
            6'h05: begin
               rd_val  = {8'h00, prescale, 5'b0,
                          irq_en, autoclr, en};
               wr_ctrl = exec & cap_we;
            end
            6'h06: begin
               rd_val  = {23'b0, flag};
               wr_stat = exec & cap_we;
            end
            6'h07: begin
               rd_val = scratch;
               wr_scr = exec & cap_we;
            end
`ifdef PBUS_WDT_EN
            6'h08: begin
               rd_val = wdt_cnt;
               wr_wdt = exec & cap_we;
            end
`endif
            default: acc_err = 1'b1;
         endcase
      end
   end

   assign clr_wr = wr_ctrl & cap_wdata[3];
   assign tick   = en & (pre == prescale) & ~clr_wr;
   assign match  = tick & (cnt == cmp);

   always_ff @(posedge clk) begin
      if (rst) begin
         req_seen       <= 1'b0;
         cap_we         <= 1'b0;
         cap_addr       <= '0;
         cap_wdata      <= '0;
         hold_err       <= 1'b0;
         hold_data      <= '0;
         bus.pbus_rdata <= '0;
      end else begin
         if (start) begin
            req_seen  <= bus.pbus_addr[31];
            cap_we    <= bus.pbus_addr[30];
            cap_addr  <= bus.pbus_addr[7:0];
            cap_wdata <= bus.pbus_wdata[23:0];
         end
         if (exec) begin
            hold_err  <= acc_err;
            hold_data <= (acc_err | cap_we) ? '0 : rd_val;
         end
         if (state == RESP)
            bus.pbus_rdata <= {req_seen, hold_err, 6'b0, hold_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= '0;
         sync2    <= '0;
         gpio_out <= '0;
         cmp      <= '0;
         scratch  <= '0;
         en       <= 1'b0;
         autoclr  <= 1'b0;
         irq_en   <= 1'b0;
         prescale <= '0;
      end else begin
         sync1 <= gpio_in;
         sync2 <= sync1;
         if (wr_gpio) gpio_out <= cap_wdata[GPIO_W-1:0];
         if (wr_cmp)  cmp      <= cap_wdata;
         if (wr_scr)  scratch  <= cap_wdata;
         if (wr_ctrl) begin
            en       <= cap_wdata[0];
            autoclr  <= cap_wdata[1];
            irq_en   <= cap_wdata[2];
            prescale <= cap_wdata[15:8];
         end
      end
   end

   // A clr write wins over any tick evaluated on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         pre  <= '0;
         flag <= 1'b0;
         irq  <= 1'b0;
      end else begin
         if (clr_wr) begin
            cnt <= '0;
            pre <= '0;
         end else if (tick) begin
            pre <= '0;
            cnt <= (match & autoclr) ? '0 : cnt + 24'd1;
         end else if (en) begin
            pre <= pre + 8'd1;
         end
         if (match)
            flag <= 1'b1;
         else if (wr_stat & cap_wdata[0])
            flag <= 1'b0;
         irq <= flag & irq_en;
      end
   end

`ifdef PBUS_WDT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_cnt <= '0;
         wdt_arm <= 1'b0;
         wdt_rst <= 1'b0;
      end else begin
         wdt_rst <= 1'b0;
         if (wr_wdt) begin
            wdt_cnt <= cap_wdata;
            wdt_arm <= |cap_wdata;
         end else if (wdt_arm) begin
            wdt_cnt <= wdt_cnt - 24'd1;
            if (wdt_cnt == 24'd1) begin
               wdt_arm <= 1'b0;
               wdt_rst <= 1'b1;
            end
         end
      end
   end
`else
   assign wdt_rst = 1'b0;
`endif
endmodule
